vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between three users:
  - display scanout, which supplies rgb to the VGA pins;
  - a pixel-writer requester using a req/ack handshake;
  - an internal clear engine.
- Sits between vga_control (h_count, v_count, bright, h_sync, v_sync) and the pins; replaces vga_display.
- Framebuffer is 160x120, 3-bit colour, upscaled 4x to 640x480.

---
 rtl/vga_fb_arbiter_pkg.sv | 28 ++
 rtl/vga_fb_arbiter_if.sv | 27 ++
 rtl/vga_fb_arbiter_clear.sv | 53 +++++
 rtl/vga_fb_arbiter.sv | 97 +++++++++
 tb/tb_vga_fb_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, types and address helper for the VGA framebuffer arbiter.
package vga_fb_arbiter_pkg;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int ADDR_W      = 15;
  localparam int RGB_W       = 3;
  localparam int FB_SIZE     = FB_W * FB_H;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  // Timing signals carried alongside the pixel fetch.
  typedef struct packed {
    logic bright;
    logic hs;
    logic vs;
  } sync_t;

  // Syncs idle high, video blanked.
  localparam sync_t SYNC_IDLE = '{bright: 1'b0, hs: 1'b1, vs: 1'b1};

  // y*160 as (y<<7)+(y<<5); keeps the row multiply to shifts and one add.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer RAM port plus pixel-writer req/ack handshake.
interface vga_fb_arbiter_if;
  import vga_fb_arbiter_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [RGB_W-1:0]  mem_wdata;
  logic [RGB_W-1:0]  mem_rdata;

  logic              wr_req;
  logic [7:0]        wr_x;
  logic [6:0]        wr_y;
  logic [RGB_W-1:0]  wr_rgb;
  logic              wr_ack;

  // Arbiter side: drives the RAM and acks the writer.
  modport master (
    output mem_addr, mem_we, mem_wdata, wr_ack,
    input  mem_rdata, wr_req, wr_x, wr_y, wr_rgb
  );

  // Environment side: RAM model and pixel writer.
  modport slave (
    input  mem_addr, mem_we, mem_wdata, wr_ack,
    output mem_rdata, wr_req, wr_x, wr_y, wr_rgb
  );
endinterface

// File: rtl/vga_fb_arbiter_clear.sv
// Clear engine: walks every framebuffer address once with a latched colour,
// advancing only when the arbiter grants it a RAM slot.
module vga_fb_clear
  import vga_fb_arbiter_pkg::*;
(
  input  logic              clk_25,
  input  logic              reset,
  input  logic              start,
  input  logic [RGB_W-1:0]  start_rgb,
  input  logic              grant,
  output logic [ADDR_W-1:0] addr,
  output logic [RGB_W-1:0]  data,
  output logic              valid,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_SIZE - 1);

  clr_state_e state;

  assign valid = (state == CLEAR);

  // Clear FSM and address counter; a start while running is ignored.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      data  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          busy  <= 1'b1;
          addr  <= '0;
          data  <= start_rgb;
        end
        CLEAR: if (grant) begin
          if (addr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scanout, a clear
// engine and a req/ack pixel writer (display > clear > writer), and drives
// the pins with rgb/hs/vs aligned 3 cycles behind the counters.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
(
  input  logic             clk_25,
  input  logic             reset,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             bright,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [RGB_W-1:0] rgb,
  output logic             hs,
  output logic             vs,
  vga_fb_arbiter_if.master bus,
  input  logic             clear_start,
  input  logic [RGB_W-1:0] clear_rgb,
  output logic             busy,
  output logic             clear_done
);
  localparam int STAGES = 3;

  logic              disp_slot, clr_valid, clr_grant, wr_grant, wr_in_range;
  logic [ADDR_W-1:0] clr_addr;
  logic [RGB_W-1:0]  clr_data, pix_q;
  logic [2:1]        vld_pipe;   // [1]: fetch address on RAM, [2]: read data back
  sync_t [STAGES:1]  sync_pipe;
  sync_t             sync_in;

  // One fetch per fb pixel: the first of each group of 4 screen pixels.
  assign disp_slot   = bright && (h_count[SCALE_SHIFT-1:0] == '0);
  assign clr_grant   = clr_valid && !disp_slot;
  assign wr_in_range = (bus.wr_x < 8'(FB_W)) && (bus.wr_y < 7'(FB_H));
  // A clear_start in the same cycle takes the engine, so the writer waits.
  assign wr_grant    = bus.wr_req && !disp_slot && !clr_valid && !clear_start && !reset;
  assign bus.wr_ack  = wr_grant;

  vga_fb_clear u_clear (
    .clk_25    (clk_25),
    .reset     (reset),
    .start     (clear_start),
    .start_rgb (clear_rgb),
    .grant     (clr_grant),
    .addr      (clr_addr),
    .data      (clr_data),
    .valid     (clr_valid),
    .busy      (busy),
    .done      (clear_done)
  );

  // RAM port register: display read, else clear write, else writer access.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else if (disp_slot) begin
      bus.mem_addr <= fb_addr(h_count[SCALE_SHIFT+7:SCALE_SHIFT],
                              v_count[SCALE_SHIFT+7:SCALE_SHIFT]);
      bus.mem_we   <= 1'b0;
    end else if (clr_grant) begin
      bus.mem_addr  <= clr_addr;
      bus.mem_we    <= 1'b1;
      bus.mem_wdata <= clr_data;
    end else if (wr_grant) begin
      // Out-of-range coordinates are acked but dropped.
      bus.mem_we <= wr_in_range;
      if (wr_in_range) begin
        bus.mem_addr  <= fb_addr(bus.wr_x, {1'b0, bus.wr_y});
        bus.mem_wdata <= bus.wr_rgb;
      end
    end else begin
      bus.mem_we <= 1'b0;
    end
  end

  assign sync_in = '{bright: bright, hs: hs_in, vs: vs_in};

  // Fetch tracking, pixel latch and sync delay line.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      vld_pipe  <= '0;
      pix_q     <= '0;
      sync_pipe <= {STAGES{SYNC_IDLE}};
    end else begin
      vld_pipe  <= {vld_pipe[1], disp_slot};
      if (vld_pipe[2]) pix_q <= bus.mem_rdata;
      sync_pipe <= {sync_pipe[STAGES-1:1], sync_in};
    end
  end

  assign rgb = sync_pipe[STAGES].bright ? pix_q : '0;
  assign hs  = sync_pipe[STAGES].hs;
  assign vs  = sync_pipe[STAGES].vs;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized scoreboard bench for vga_fb_arbiter: a framebuffer-level model
// predicts RAM traffic, writer acks, clear status and pin outputs per cycle.
module tb_vga_fb_arbiter;
  import vga_fb_arbiter_pkg::*;

  typedef enum int {K_IDLE, K_READ, K_WRITE, K_RESET, K_OOR} kind_e;
  typedef struct { int cyc; kind_e kind; int addr; int data; bit busy; bit done; } mem_exp_t;
  typedef struct { int cyc; int rgb; bit hs; bit vs; } pin_exp_t;
  typedef struct { int cyc; bit ack; } ack_exp_t;

  logic             clk_25 = 1'b0;
  logic             reset;
  logic [9:0]       h_count, v_count;
  logic             bright, hs_in, vs_in;
  logic [RGB_W-1:0] rgb;
  logic             hs, vs;
  logic             clear_start;
  logic [RGB_W-1:0] clear_rgb;
  logic             busy, clear_done;

  vga_fb_arbiter_if bus();

  vga_fb_arbiter dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .h_count     (h_count),
    .v_count     (v_count),
    .bright      (bright),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .rgb         (rgb),
    .hs          (hs),
    .vs          (vs),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_rgb   (clear_rgb),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  always #20 clk_25 = ~clk_25;

  // Single-port synchronous RAM, one-cycle read latency.
  logic [RGB_W-1:0] ram [0:32767];
  always @(posedge clk_25) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference model state.
  logic [RGB_W-1:0] fb [0:FB_SIZE-1];
  int  cyc = 0;
  bit  m_clearing = 0;
  int  m_clr_addr = 0, m_clr_rgb = 0, m_pix = 0, m_last_addr = 0;
  mem_exp_t q_mem[$];
  pin_exp_t q_pin[$];
  ack_exp_t q_ack[$];
  int  n_chk = 0, n_fail = 0;

  // Stimulus control.
  bit  video_on = 0, wr_en = 0, wr_arm = 0, ack_seen = 0;
  bit  pend_clear = 0, pend_wr = 0;
  int  pend_rst = 0, pend_rgb = 0, v_force = -1, wi = 0;
  int  tx[3] = '{3, 160, 159};
  int  ty[3] = '{2, 0, 119};
  int  trgb[3] = '{6, 5, 4};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic new_req();
    bus.wr_req = 1'b1;
    if (wi < 3) begin
      bus.wr_x = 8'(tx[wi]); bus.wr_y = 7'(ty[wi]); bus.wr_rgb = 3'(trgb[wi]);
    end else begin
      bus.wr_x = 8'($urandom_range(0, 175));
      bus.wr_y = 7'($urandom_range(0, 127));
      bus.wr_rgb = 3'($urandom);
    end
    wi++;
  endtask

  // Predict this cycle's outcome from the behavioural rules.
  task automatic model_step();
    mem_exp_t m;
    pin_exp_t p;
    ack_exp_t a;
    pin_exp_t keep[$];
    bit was_clr, disp;
    a.cyc = cyc; a.ack = 0;
    m.cyc = cyc + 1; m.kind = K_IDLE; m.addr = m_last_addr; m.data = 0; m.done = 0; m.busy = 0;
    if (reset) begin
      m_clearing = 0; m_pix = 0; m_last_addr = 0;
      m.kind = K_RESET; m.addr = 0;
      foreach (q_pin[i]) if (q_pin[i].cyc <= cyc) keep.push_back(q_pin[i]);
      q_pin = keep;
      for (int k = 1; k <= 3; k++) begin
        p.cyc = cyc + k; p.rgb = 0; p.hs = 1; p.vs = 1;
        q_pin.push_back(p);
      end
    end else begin
      was_clr = m_clearing;
      disp = bright && (h_count % 4 == 0);
      if (disp) begin
        m.kind = K_READ;
        m.addr = (int'(v_count) / 4) * FB_W + int'(h_count) / 4;
        m_pix = int'(fb[m.addr]);
      end else if (m_clearing) begin
        m.kind = K_WRITE; m.addr = m_clr_addr; m.data = m_clr_rgb;
        fb[m_clr_addr] = 3'(m_clr_rgb);
        if (m_clr_addr == FB_SIZE - 1) begin
          m_clearing = 0; m.done = 1;
        end else m_clr_addr++;
      end else if (bus.wr_req && !clear_start) begin
        a.ack = 1;
        if (int'(bus.wr_x) < FB_W && int'(bus.wr_y) < FB_H) begin
          m.kind = K_WRITE;
          m.addr = int'(bus.wr_y) * FB_W + int'(bus.wr_x);
          m.data = int'(bus.wr_rgb);
          fb[m.addr] = bus.wr_rgb;
        end else m.kind = K_OOR;
      end
      if (clear_start && !was_clr) begin
        m_clearing = 1; m_clr_addr = 0; m_clr_rgb = int'(clear_rgb);
      end
      m.busy = m_clearing;
      if (m.kind == K_READ || m.kind == K_WRITE) m_last_addr = m.addr;
      p.cyc = cyc + 3; p.rgb = bright ? m_pix : 0; p.hs = hs_in; p.vs = vs_in;
      q_pin.push_back(p);
    end
    q_mem.push_back(m);
    q_ack.push_back(a);
  endtask

  // One clock: sample the writer ack, then drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk_25);
    ack_seen = bus.wr_ack;
    @(posedge clk_25);
    #1;
    cyc++;
    reset = (pend_rst > 0);
    if (pend_rst > 0) pend_rst--;
    clear_start = pend_clear;
    if (pend_clear) clear_rgb = 3'(pend_rgb);
    pend_clear = 0;
    if (h_count == 10'd799) begin
      h_count = '0;
      if (v_force >= 0) begin v_count = 10'(v_force); v_force = -1; end
      else if (video_on) v_count = 10'($urandom_range(0, 524));
      else v_count = 10'($urandom_range(480, 524));
    end else h_count = h_count + 10'd1;
    bright = video_on && h_count < 640 && v_count < 480;
    hs_in = !(h_count >= 656 && h_count < 752);
    vs_in = !(v_count == 490 || v_count == 491);
    if (bus.wr_req && ack_seen) begin
      if (wr_en && $urandom_range(0, 1) == 1) new_req();
      else bus.wr_req = 1'b0;
    end
    if (wr_arm && bright && h_count == 10'd12 && v_count == 10'd4) begin
      wr_arm = 0; wr_en = 1; new_req();
    end else if (!bus.wr_req && wr_en && $urandom_range(0, 3) == 0) new_req();
    if (pend_wr) begin
      pend_wr = 0; bus.wr_req = 1'b1; bus.wr_x = 8'd5; bus.wr_y = 7'd5; bus.wr_rgb = 3'd1;
    end
    model_step();
  endtask

  // Monitor: compare DUT outputs against queued expectations each cycle.
  initial begin : monitor
    ack_exp_t a;
    mem_exp_t m;
    pin_exp_t p;
    forever begin
      @(negedge clk_25);
      while (q_ack.size() > 0 && q_ack[0].cyc <= cyc) begin
        a = q_ack.pop_front();
        if (a.cyc == cyc) chk("wr_ack", int'(bus.wr_ack), int'(a.ack));
        else chk("ack_stale", a.cyc, cyc);
      end
      while (q_mem.size() > 0 && q_mem[0].cyc <= cyc) begin
        m = q_mem.pop_front();
        if (m.cyc != cyc) chk("mem_stale", m.cyc, cyc);
        else begin
          chk("mem_we", int'(bus.mem_we), int'(m.kind == K_WRITE));
          if (m.kind != K_OOR) chk("mem_addr", int'(bus.mem_addr), m.addr);
          if (m.kind == K_WRITE || m.kind == K_RESET) chk("mem_wdata", int'(bus.mem_wdata), m.data);
          chk("busy", int'(busy), int'(m.busy));
          chk("clear_done", int'(clear_done), int'(m.done));
        end
      end
      while (q_pin.size() > 0 && q_pin[0].cyc <= cyc) begin
        p = q_pin.pop_front();
        if (p.cyc != cyc) chk("pin_stale", p.cyc, cyc);
        else begin
          chk("rgb", int'(rgb), p.rgb);
          chk("hs", int'(hs), int'(p.hs));
          chk("vs", int'(vs), int'(p.vs));
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1; clear_start = 1'b0; clear_rgb = '0;
    h_count = 10'd799; v_count = 10'd500; bright = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    bus.wr_req = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
    for (int i = 0; i < 32768; i++) ram[i] = 3'($urandom);
    ram[162] = 3'b101;
    for (int i = 0; i < FB_SIZE; i++) fb[i] = ram[i];

    // Reset held two cycles, then idle with no requests.
    pend_rst = 2;
    repeat (2) tick();
    repeat (20) tick();

    // Active video with directed then random writes; first line is v=4.
    video_on = 1; v_force = 4; wr_arm = 1;
    repeat (4000) tick();

    // Full clear in blanking with a writer request colliding on clear_start.
    video_on = 0; wr_en = 0;
    for (int i = 0; i < 200 && bus.wr_req; i++) tick();
    if (bus.wr_req) chk("writer_drain", 1, 0);
    pend_clear = 1; pend_rgb = 3; pend_wr = 1;
    tick();
    repeat (100) tick();
    pend_clear = 1; pend_rgb = 7;
    tick();
    for (int i = 0; i < 19400 && m_clearing; i++) tick();
    repeat (20) tick();

    // Clear during active video abandoned by reset.
    video_on = 1;
    pend_clear = 1; pend_rgb = 2;
    repeat (1000) tick();
    pend_rst = 1;
    tick();
    repeat (300) tick();

    // Random traffic again over the partly cleared framebuffer.
    wr_en = 1;
    repeat (3200) tick();
    wr_en = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
